// File: rtl/mult_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // Counter must be able to hold WIDTH itself.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mult_twos_cond.sv
// Conditional two's-complement negate: y = en ? -x : x.
module mult_twos_cond #(
    parameter int N = 8
) (
    input  logic         en,
    input  logic [N-1:0] x,
    output logic [N-1:0] y
);

    assign y = en ? (~x + N'(1)) : x;

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, one partial product per clock, signed or unsigned per operation.
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 mult_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    mult_state_t          state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 in_ready_q, out_valid_q, busy_q;

    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [2*WIDTH-1:0]   acc_sum, acc_signed;

    mult_twos_cond #(.N(WIDTH)) u_neg_a (
        .en (mult_mode & a[WIDTH-1]),
        .x  (a),
        .y  (a_mag)
    );

    mult_twos_cond #(.N(WIDTH)) u_neg_b (
        .en (mult_mode & b[WIDTH-1]),
        .x  (b),
        .y  (b_mag)
    );

    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    mult_twos_cond #(.N(2*WIDTH)) u_neg_p (
        .en (neg_q),
        .x  (acc_sum),
        .y  (acc_signed)
    );

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        product_d = product_q;
        unique case (state_q)
            IDLE: begin
                // in_ready_q is low for one cycle after reset release, so gate on it.
                if (in_valid && in_ready_q) begin
                    neg_d    = mult_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    mcand_d  = {{WIDTH{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    product_d = acc_signed;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            product_q   <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            product_q   <= product_d;
            // Handshake flags are registered decodes of the next state.
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign product   = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier (WIDTH=8): directed table, corner sequences, random ops.
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        mult_mode = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] product;
    logic        busy;

    int checks = 0;
    int failures = 0;

    seq_multiplier #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .mult_mode (mult_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        m;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer multiply of the operands as interpreted by the mode.
    function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y, input logic m);
        int xi, yi;
        xi = m ? int'($signed(x)) : int'(x);
        yi = m ? int'($signed(y)) : int'(y);
        return 16'(xi * yi);
    endfunction

    // One full operation: accept, wait for result, stall, handshake (with in_valid held high).
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_b, input logic tm,
                          input int stall, input logic [15:0] exp, input string tag);
        int n;
        int lat;
        logic [15:0] res;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_in_ready_before_accept"}, 32'(in_ready), 32'd1);
        a = ta; b = tb_b; mult_mode = tm; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); mult_mode = 1'($urandom);
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        chk({tag, "_latency_edges"}, 32'(lat), 32'd9);
        res = product;
        chk({tag, "_product"}, 32'(res), 32'(exp));
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
            @(posedge clk); #1;
            chk({tag, "_stall_product"}, 32'(product), 32'(res));
            chk({tag, "_stall_out_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk({tag, "_out_valid_after_hs"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready_after_hs"}, 32'(in_ready), 32'd1);
        chk({tag, "_busy_after_hs"}, 32'(busy), 32'd0);
        $display("op %s a=%02h b=%02h mode=%0d product=%04h expected=%04h latency=%0d stall=%0d",
                 tag, ta, tb_b, tm, res, exp, lat, stall);
    endtask

    initial begin
        vecs[0] = '{a: 8'hFF, b: 8'hFF, m: 1'b0, exp: 16'hFE01};
        vecs[1] = '{a: 8'h80, b: 8'h80, m: 1'b1, exp: 16'h4000};
        vecs[2] = '{a: 8'hFD, b: 8'h05, m: 1'b1, exp: 16'hFFF1};
        vecs[3] = '{a: 8'h80, b: 8'h02, m: 1'b0, exp: 16'h0100};
        vecs[4] = '{a: 8'h80, b: 8'h02, m: 1'b1, exp: 16'hFF00};
        vecs[5] = '{a: 8'h00, b: 8'h81, m: 1'b1, exp: 16'h0000};
        vecs[6] = '{a: 8'h07, b: 8'h06, m: 1'b0, exp: 16'h002A};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_product", 32'(product), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("release_in_ready", 32'(in_ready), 32'd1);
        $display("reset released in_ready=%0d", in_ready);

        // Directed table
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].m, 0, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Backpressure: 5 stall cycles with inputs toggling
        run_op(8'hFD, 8'h05, 1'b1, 5, 16'hFFF1, "backpressure");

        // Reset during the 4th CALC cycle of a nonzero-result op
        a = 8'hFF; b = 8'hFF; mult_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("midop_busy_before", 32'(busy), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("midop_busy_in_calc", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midop_out_valid", 32'(out_valid), 32'd0);
        chk("midop_busy", 32'(busy), 32'd0);
        chk("midop_product", 32'(product), 32'd0);
        chk("midop_in_ready", 32'(in_ready), 32'd0);
        $display("reset asserted mid-CALC out_valid=%0d busy=%0d product=%04h", out_valid, busy, product);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midop_release_in_ready", 32'(in_ready), 32'd1);
        chk("midop_release_out_valid", 32'(out_valid), 32'd0);
        run_op(8'h07, 8'h06, 1'b0, 0, 16'h002A, "after_reset");

        // Randomised against the arithmetic model
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] ra, rb;
            logic rm;
            int st;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rm = 1'($urandom);
            st = (($urandom % 4) == 0) ? int'($urandom_range(1, 4)) : 0;
            run_op(ra, rb, rm, st, model(ra, rb, rm), $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
